// File: rtl/icache_axi_rd_pkg.sv
// ----------------------------------------------------------------------------
// icache_axi_rd_pkg
// Shared definitions for the icache line-fill AXI4 read master:
//   - FSM state encoding (IDLE, ADDR, DATA, DONE)
//   - AXI burst/response encodings, the icache AXI ID and the 8-byte beat size
//   - helper that turns the icache beat count into the index of the last beat
// ----------------------------------------------------------------------------
package icache_axi_rd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } icache_rd_state_e;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
  localparam logic [3:0] ICACHE_ID      = 4'h3;
  localparam logic [1:0] SIZE_D         = 2'b11;  // log2(8 bytes)

  // Icache beat count encoding: 0 means one beat, otherwise the value is the
  // beat count. Returns beats-1, which is both AXI len and the last beat index.
  function automatic logic [1:0] beats_m1(input logic [1:0] len);
    return (len == 2'd0) ? 2'd0 : (len - 2'd1);
  endfunction

endpackage

// File: rtl/icache_axi_rd.sv
// ----------------------------------------------------------------------------
// icache_axi_rd
// AXI4 read master serving icache line fills. One request becomes one INCR
// burst; every R beat is registered and presented to the icache as a
// one-cycle if_burst_ready pulse, in ascending order. Only one AXI
// transaction is ever outstanding.
//
// Ports
//   cpu_clk_50M, cpu_rst_n      clock, asynchronous active-low reset
//   if_burst_valid/addr/len/size  icache fill request (held through the fill)
//   if_burst_ready/data         per-beat pulse and registered beat data
//   ar_*                        AXI4 read address channel
//   r_*                         AXI4 read data channel
//   bus_err                     sticky error flag (r_last misplaced, bad r_id,
//                               and bad r_resp when the check is enabled)
//
// Build option
//   ICACHE_AXI_RESP_CHECK_EN    when defined, r_resp != OKAY flags bus_err and
//                               zeroes that beat's data; otherwise r_resp is
//                               ignored.
// ----------------------------------------------------------------------------
module icache_axi_rd
  import icache_axi_rd_pkg::*;
(
  input  logic        cpu_clk_50M,
  input  logic        cpu_rst_n,
  // icache side
  input  logic        if_burst_valid,
  input  logic [63:4] if_burst_addr,
  input  logic [1:0]  if_burst_len,
  input  logic [1:0]  if_burst_size,
  output logic        if_burst_ready,
  output logic [63:0] if_burst_data,
  // AXI read address channel
  output logic        ar_valid,
  input  logic        ar_ready,
  output logic [63:0] ar_addr,
  output logic [7:0]  ar_len,
  output logic [2:0]  ar_size,
  output logic [1:0]  ar_burst,
  output logic [3:0]  ar_id,
  // AXI read data channel
  input  logic        r_valid,
  output logic        r_ready,
  input  logic [63:0] r_data,
  input  logic [1:0]  r_resp,
  input  logic        r_last,
  input  logic [3:0]  r_id,
  // status
  output logic        bus_err
);

  icache_rd_state_e state_q;

  logic        ar_valid_q;
  logic [63:0] ar_addr_q;
  logic [7:0]  ar_len_q;
  logic [2:0]  ar_size_q;
  logic [1:0]  ar_burst_q;
  logic [3:0]  ar_id_q;
  logic        r_ready_q;
  logic        if_burst_ready_q;
  logic [63:0] if_burst_data_q;
  logic        bus_err_q;
  logic [1:0]  beat_cnt_q;
  logic [1:0]  last_idx_q;

  logic        r_hs;
  logic        final_beat;
  logic        last_err;
  logic        id_err;
  logic        resp_err;
  logic [63:0] rdata_d;
  logic        bus_err_d;

  // Beat qualification. The beat counter alone decides completion; r_last
  // is only cross-checked against it.
  always_comb begin
    r_hs       = (state_q == DATA) && r_valid && r_ready_q;
    final_beat = (beat_cnt_q == last_idx_q);
    last_err   = (r_last != final_beat);
    id_err     = (r_id != ICACHE_ID);
`ifdef ICACHE_AXI_RESP_CHECK_EN
    resp_err   = (r_resp != AXI_RESP_OKAY);
    rdata_d    = resp_err ? '0 : r_data;
`else
    resp_err   = 1'b0;
    rdata_d    = r_data;
`endif
    bus_err_d  = bus_err_q | (r_hs & (last_err | id_err | resp_err));
  end

`ifndef ICACHE_AXI_RESP_CHECK_EN
  logic unused_resp;
  assign unused_resp = ^r_resp;
`endif

  always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      state_q          <= IDLE;
      ar_valid_q       <= 1'b0;
      ar_addr_q        <= '0;
      ar_len_q         <= '0;
      ar_size_q        <= '0;
      ar_burst_q       <= '0;
      ar_id_q          <= '0;
      r_ready_q        <= 1'b0;
      if_burst_ready_q <= 1'b0;
      if_burst_data_q  <= '0;
      bus_err_q        <= 1'b0;
      beat_cnt_q       <= '0;
      last_idx_q       <= '0;
    end else begin
      if_burst_ready_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (if_burst_valid) begin
            state_q    <= ADDR;
            ar_valid_q <= 1'b1;
            ar_addr_q  <= {if_burst_addr, 4'b0000};
            ar_len_q   <= {6'd0, beats_m1(if_burst_len)};
            ar_size_q  <= {1'b0, if_burst_size};
            ar_burst_q <= AXI_BURST_INCR;
            ar_id_q    <= ICACHE_ID;
            last_idx_q <= beats_m1(if_burst_len);
            beat_cnt_q <= '0;
          end
        end
        ADDR: begin
          // AR fields stay frozen until accepted; dropping the request here
          // does not abort the transaction.
          if (ar_valid_q && ar_ready) begin
            ar_valid_q <= 1'b0;
            r_ready_q  <= 1'b1;
            state_q    <= DATA;
          end
        end
        DATA: begin
          if (r_hs) begin
            if_burst_data_q  <= rdata_d;
            if_burst_ready_q <= 1'b1;
            beat_cnt_q       <= beat_cnt_q + 2'd1;
            bus_err_q        <= bus_err_d;
            if (final_beat) begin
              r_ready_q <= 1'b0;
              state_q   <= DONE;
            end
          end
        end
        DONE: begin
          // Wait for the icache to withdraw the request so it is not reissued.
          if (!if_burst_valid) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ar_valid       = ar_valid_q;
  assign ar_addr        = ar_addr_q;
  assign ar_len         = ar_len_q;
  assign ar_size        = ar_size_q;
  assign ar_burst       = ar_burst_q;
  assign ar_id          = ar_id_q;
  assign r_ready        = r_ready_q;
  assign if_burst_ready = if_burst_ready_q;
  assign if_burst_data  = if_burst_data_q;
  assign bus_err        = bus_err_q;

endmodule
